deficit_round_robin_arbiter: RTL and testbench

Deficit round-robin (DRR) arbiter that shares one transfer resource between N requesters. Each request carries a transfer length, so bandwidth is split fairly in length units rather than in grants. A grant is held until the granted master signals completion. The block sits alongside the round-robin arbiters on the shared bus, in front of any master whose transfers vary in size.

---
 rtl/drr_arb_pkg.sv | 20 ++
 rtl/drr_deficit_bank.sv | 49 ++++
 rtl/deficit_round_robin_arbiter.sv | 128 ++++++++++++
 tb/tb_deficit_round_robin_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drr_arb_pkg.sv
// Shared types, default sizing and helpers for the deficit round-robin arbiter.
// Imported by the arbiter top level and its deficit bank.
package drr_arb_pkg;

    typedef enum logic {
        SCAN  = 1'b0,
        GRANT = 1'b1
    } drr_state_e;

    localparam int DRR_N       = 4;
    localparam int DRR_LEN_W   = 8;
    localparam int DRR_QUANTUM = 64;
    localparam int DRR_DEF_W   = DRR_LEN_W + 1;

    // One-hot of an index, up to 32 ports; callers size-cast to their own width.
    function automatic logic [31:0] drr_onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Bank of per-requester deficit counters with clear, add-quantum and subtract
// ports, plus one combinational read port.
module drr_deficit_bank
    import drr_arb_pkg::*;
#(
    parameter int N       = DRR_N,
    parameter int DEF_W   = DRR_DEF_W,
    parameter int QUANTUM = DRR_QUANTUM,
    parameter int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic             i_add_en,
    input  logic [IDX_W-1:0] i_add_idx,
    input  logic             i_sub_en,
    input  logic [IDX_W-1:0] i_sub_idx,
    input  logic [DEF_W-1:0] i_sub_amt,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [DEF_W-1:0] o_rd_data
);

    logic [DEF_W-1:0] r_deficit [N];

    // NOTE: the counters are architectural state that must start at zero, so this
    // small register array is reset explicitly rather than treated as a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_deficit[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_clr_en && i_clr_idx == IDX_W'(i))
                    r_deficit[i] <= '0;
                else if (i_add_en && i_add_idx == IDX_W'(i))
                    r_deficit[i] <= r_deficit[i] + DEF_W'(QUANTUM);
                else if (i_sub_en && i_sub_idx == IDX_W'(i))
                    r_deficit[i] <= r_deficit[i] - i_sub_amt;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < N; i++)
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_deficit[i];
    end

endmodule

// File: rtl/deficit_round_robin_arbiter.sv
// Deficit round-robin arbiter: one scan decision per cycle at the pointer, and a
// grant held until the owning master pulses DONE.
module deficit_round_robin_arbiter
    import drr_arb_pkg::*;
#(
    parameter int N       = DRR_N,
    parameter int LEN_W   = DRR_LEN_W,
    parameter int QUANTUM = DRR_QUANTUM,
    parameter int PTR_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       REQ,
    input  logic [N*LEN_W-1:0] LEN,
    input  logic               DONE,
    output logic [N-1:0]       GNT,
    output logic [PTR_W-1:0]   GNT_ID,
    output logic               BUSY
);

    localparam int DEF_W = LEN_W + 1;

    drr_state_e       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_fresh;
    logic [N-1:0]     r_gnt;
    logic [PTR_W-1:0] r_gnt_id;
    logic             r_busy;

    logic             w_req_cur;
    logic [LEN_W-1:0] w_len_cur;
    logic [DEF_W-1:0] w_eff_len;
    logic [DEF_W-1:0] w_def_cur;
    logic             w_fits;
    logic             w_scan;
    logic             w_clr_en;
    logic             w_add_en;
    logic             w_sub_en;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N-1:0]     w_ptr_onehot;

    // NOTE: every combinational output gets a default before the mux loop, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_req_cur = 1'b0;
        w_len_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ptr == PTR_W'(i)) begin
                w_req_cur = REQ[i];
                w_len_cur = LEN[i*LEN_W +: LEN_W];
            end
        end
    end

    // A zero-length transfer still occupies the resource, so it is charged as 1.
    assign w_eff_len    = (w_len_cur == '0) ? DEF_W'(1) : {1'b0, w_len_cur};
    assign w_fits       = (w_eff_len <= w_def_cur);
    assign w_scan       = (r_state == SCAN);
    assign w_clr_en     = w_scan && !w_req_cur;
    assign w_add_en     = w_scan && w_req_cur && r_fresh;
    assign w_sub_en     = w_scan && w_req_cur && !r_fresh && w_fits;
    assign w_ptr_next   = (r_ptr == PTR_W'(N - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_onehot = N'(drr_onehot(int'(r_ptr)));

    drr_deficit_bank #(
        .N       (N),
        .DEF_W   (DEF_W),
        .QUANTUM (QUANTUM)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_clr_en  (w_clr_en),
        .i_clr_idx (r_ptr),
        .i_add_en  (w_add_en),
        .i_add_idx (r_ptr),
        .i_sub_en  (w_sub_en),
        .i_sub_idx (r_ptr),
        .i_sub_amt (w_eff_len),
        .i_rd_idx  (r_ptr),
        .o_rd_data (w_def_cur)
    );

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, matching the hardware it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SCAN;
            r_ptr    <= '0;
            r_fresh  <= 1'b1;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (!w_req_cur) begin
                        r_ptr   <= w_ptr_next;
                        r_fresh <= 1'b1;
                    end else if (r_fresh) begin
                        r_fresh <= 1'b0;
                    end else if (w_fits) begin
                        r_gnt    <= w_ptr_onehot;
                        r_gnt_id <= r_ptr;
                        r_busy   <= 1'b1;
                        r_state  <= GRANT;
                    end else begin
                        r_ptr   <= w_ptr_next;
                        r_fresh <= 1'b1;
                    end
                end
                GRANT: begin
                    // Returning with fresh clear lets the same port spend its leftover deficit.
                    if (DONE) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_fresh <= 1'b0;
                        r_state <= SCAN;
                    end
                end
            endcase
        end
    end

    assign GNT    = r_gnt;
    assign GNT_ID = r_gnt_id;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_deficit_round_robin_arbiter.sv
// Self-checking bench for deficit_round_robin_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a behavioural DRR model.
module tb_deficit_round_robin_arbiter;

    localparam int N = 4;
    localparam int LW = 8;
    localparam int Q = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*LW-1:0] len;
    logic          done;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain integers per port, one scheduling decision per clock.
    int m_def [N];
    int m_ptr;
    bit m_fresh;
    bit m_busy;
    int m_gid;

    deficit_round_robin_arbiter #(.N(N), .LEN_W(LW), .QUANTUM(Q)) dut (
        .clk    (clk),
        .rst    (rst),
        .REQ    (req),
        .LEN    (len),
        .DONE   (done),
        .GNT    (gnt),
        .GNT_ID (gnt_id),
        .BUSY   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int port_len(input int p);
        return int'(len[p*LW +: LW]);
    endfunction

    task automatic set_len(input int p, input int v);
        len[p*LW +: LW] = LW'(v);
    endtask

    task automatic model_step();
        int p;
        int e;
        if (rst) begin
            for (int i = 0; i < N; i++) m_def[i] = 0;
            m_ptr = 0; m_fresh = 1; m_busy = 0; m_gid = 0;
        end else if (m_busy) begin
            if (done) begin
                m_busy = 0;
                m_fresh = 0;
            end
        end else begin
            p = m_ptr;
            e = (port_len(p) == 0) ? 1 : port_len(p);
            if (!req[p]) begin
                m_def[p] = 0; m_ptr = (p + 1) % N; m_fresh = 1;
            end else if (m_fresh) begin
                m_def[p] += Q; m_fresh = 0;
            end else if (e <= m_def[p]) begin
                m_def[p] -= e; m_busy = 1; m_gid = p;
            end else begin
                m_ptr = (p + 1) % N; m_fresh = 1;
            end
        end
    endtask

    task automatic compare();
        check("gnt", int'(gnt), m_busy ? (1 << m_gid) : 0);
        check("busy", int'(busy), int'(m_busy));
        if (m_busy) check("gnt_id", int'(gnt_id), m_gid);
    endtask

    // One clock: inputs already driven, model advances on the same edge, compare 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1; done = 0;
        cycle();
        rst = 0;
    endtask

    task automatic finish_grant();
        done = 1;
        cycle();
        done = 0;
        check("gnt_after_done", int'(gnt), 0);
    endtask

    int order [20];
    int cnt [N];
    int n_gr;
    int wait_c;
    bit pb;

    initial begin
        rst = 1; req = '0; len = '0; done = 0;

        // Reset held two cycles with all ports requesting length 10.
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_len(i, 10);
        repeat (2) begin
            cycle();
            check("rst_gnt", int'(gnt), 0);
            check("rst_busy", int'(busy), 0);
        end
        rst = 0;
        cycle();
        check("t1_credit_gnt", int'(gnt), 0);
        cycle();
        check("t1_gnt", int'(gnt), 4'b0001);
        check("t1_model_def0", m_def[0], 54);
        finish_grant();

        // Long single request: two credited visits needed, grant on the 9th edge.
        req = 4'b0100;
        set_len(2, 100);
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("t2_pre_gnt", int'(gnt), 0);
        end
        cycle();
        check("t2_gnt", int'(gnt), 4'b0100);
        check("t2_gnt_id", int'(gnt_id), 2);
        check("t2_model_def2", m_def[2], 28);
        finish_grant();

        // Deficit cleared when the request drops before the next visit.
        req = 4'b0010;
        set_len(1, 100);
        do_reset();
        repeat (3) cycle();
        req = 4'b0000;
        repeat (4) cycle();
        check("t4_model_def1", m_def[1], 0);
        req = 4'b0010;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            check("t4_pre_gnt", int'(gnt), 0);
        end
        cycle();
        check("t4_gnt", int'(gnt), 4'b0010);
        finish_grant();

        // Grant ownership: REQ drop does not release, idle DONE is ignored.
        req = 4'b1000;
        set_len(3, 5);
        do_reset();
        repeat (5) cycle();
        check("t5_gnt", int'(gnt), 4'b1000);
        req = 4'b0000;
        repeat (3) begin
            cycle();
            check("t5_hold", int'(gnt), 4'b1000);
        end
        finish_grant();
        repeat (3) begin
            done = 1;
            cycle();
            check("t5_idle_done", int'(busy), 0);
        end
        done = 0;

        // Reset in the middle of a grant to port 1.
        req = 4'b0010;
        set_len(1, 10);
        do_reset();
        repeat (3) cycle();
        check("t6_gnt", int'(gnt), 4'b0010);
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_len(i, 10);
        rst = 1;
        cycle();
        rst = 0;
        check("t6_rst_gnt", int'(gnt), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_id", int'(gnt_id), 0);
        repeat (2) cycle();
        check("t6_regrant", int'(gnt), 4'b0001);
        finish_grant();

        // Fairness: port 0 asks for half the length, so it wins twice per round.
        req = 4'b1111;
        set_len(0, 32);
        for (int i = 1; i < N; i++) set_len(i, 64);
        do_reset();
        n_gr = 0; wait_c = 0; pb = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 400 && n_gr < 20; c++) begin
            cycle();
            done = 0;
            if (busy && !pb) begin
                order[n_gr] = int'(gnt_id);
                cnt[gnt_id]++;
                n_gr++;
                wait_c = 0;
            end else if (busy) begin
                wait_c++;
            end
            if (busy && wait_c == 2) done = 1;
            pb = busy;
        end
        done = 0;
        if (n_gr < 20) begin
            n_checks++; n_errors++;
            $display("FAIL fair_timeout grants=%0d required=20", n_gr);
        end else begin
            for (int k = 0; k < 10; k++)
                check("fair_order", order[k], (k % 5 < 2) ? 0 : (k % 5) - 1);
            check("fair_cnt0", cnt[0], 8);
            for (int i = 1; i < N; i++) check("fair_cnt", cnt[i], 4);
        end

        // Randomized traffic, including zero lengths, idle DONEs and stray resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                if (!req[i] && $urandom_range(0, 3) == 0)
                    set_len(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
            end
            done = 0;
            if (m_busy && $urandom_range(0, 3) == 0) done = 1;
            else if (!m_busy && $urandom_range(0, 7) == 0) done = 1;
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 0; done = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
